cla8_seq_adder: RTL and testbench
=================================

# cla8_seq_adder

Multi-cycle wide integer adder/subtractor built from one CLA_8 slice, reused over time. It adds WIDTH-bit operands one byte lane per cycle, least significant byte first, and carries between lanes through a registered carry. It sits in the FPU beside the mantissa/exponent datapath, where area matters more than latency. Valid/ready handshakes on both sides let an upstream issue stage and a downstream writeback stage stall it.

## Interface
- WIDTH, 32, operand width; must be a multiple of 8 and at least 8.
- NUM_BYTES, WIDTH/8, derived lane count; must not be overridden.

- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block idle, able to accept.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for add mode.
- sub  in  1  1 = compute a − b (see Configuration).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of bit WIDTH−1.
- ovf  out  1  two's-complement signed overflow.

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture a into a_r and b_eff into b_r, where b_eff = sub ? ~b : b.
  - Set carry_r = sub ? 1 : cin, lane counter k=0, and go to RUN.
- RUN:
  - Each cycle the CLA_8 slice gets a_r[8k+:8], b_r[8k+:8] and carry_r.
  - Its sum is written to sum[8k+:8] and its cOut to carry_r; k increments.
  - When k==NUM_BYTES−1 is processed, go to DONE.
- DONE:
  - out_valid=1, cout=carry_r.
  - ovf = (a_r[MSB]==b_r[MSB]) && (sum[MSB]!=a_r[MSB]).
  - On out_ready, go to IDLE.
- Arithmetic: the full WIDTH+1-bit result {cout,sum} = a + b_eff + carry_init, modulo 2^(WIDTH+1).
- in_ready is 0 in RUN and DONE. in_valid there is ignored, and nothing is captured.
- Operands are registered. Input changes after acceptance have no effect.
- sum, cout and ovf hold stable while out_valid=1 and out_ready=0.
- Reset, including mid-RUN or mid-DONE:
  - Next state IDLE; any in-flight operation is discarded with no partial result emitted.
  - sum=0, cout=0, ovf=0, out_valid=0, k=0, carry_r=0.
  - in_ready=0 while rst is high.

## Timing
- Accepting edge: in_valid && in_ready at edge E0.
- sum lanes update at edges E1..E_NUM_BYTES.
- out_valid rises after edge E_NUM_BYTES, giving a latency of NUM_BYTES cycles (4 for WIDTH=32).
- Handshake in DONE at edge Ed returns to IDLE. in_ready=1 in the following cycle.
- Back-to-back issue period is NUM_BYTES+2 cycles minimum.
- Combinational paths:
  - in_ready and out_valid are decoded from the state register only.
  - No combinational path from in_valid or out_ready to any output.
- The critical path is one CLA_8 slice plus the lane mux, independent of WIDTH.

## Configuration
- CLA_SEQ_SUB_EN defined:
  - sub is honoured: b is inverted and the initial carry is 1, ignoring cin.
  - cout=1 means no borrow.
- CLA_SEQ_SUB_EN undefined:
  - The sub port remains but is ignored, treated as 0.
  - b is never inverted and the initial carry is cin. The inversion muxes are not synthesised.

## Test plan
- a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, cout=0, ovf=0; out_valid exactly 4 cycles after the accepting edge.
- a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0; the carry ripples through all 4 lanes.
- a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
- Subtract, sub=1:
  - With CLA_SEQ_SUB_EN, a=7, b=5 -> sum=2, cout=1; a=5, b=7 -> sum=0xFFFFFFFE, cout=0.
  - Without CLA_SEQ_SUB_EN, a=5, b=7, cin=0 -> sum=12.
- Backpressure: hold out_ready=0 for 3 cycles in DONE and pulse in_valid with new operands -> sum/cout/ovf unchanged, in_ready=0, the new request is not captured; result drops one cycle after out_ready=1.
- Reset mid-RUN: assert rst after 2 lanes are done -> next cycle out_valid=0, sum=0, in_ready=0; after rst deasserts, in_ready=1 and the next operation, 0x12345678+0x11111111, gives 0x23456789.

Source files
------------

// File: rtl/cla8_seq_adder.sv
// cla8_seq_adder: multi-cycle WIDTH-bit adder/subtractor that reuses one 8-bit
// carry-lookahead slice. It processes one byte lane per cycle, least significant
// lane first, and passes the carry between lanes through a register.
// Optional feature macro: CLA_SEQ_SUB_EN. When it is defined, the sub input
// selects a - b. When it is undefined, sub is ignored.
module cla8_seq_adder #(
  parameter int WIDTH     = 32,
  parameter int NUM_BYTES = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int K_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [K_W-1:0]   k_q, k_d;

  logic [WIDTH-1:0] b_eff;
  logic             carry_init;

  // Operand conditioning at capture time. The inversion exists only when
  // subtraction is enabled.
`ifdef CLA_SEQ_SUB_EN
  assign b_eff      = sub ? ~b : b;
  assign carry_init = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign carry_init = cin;
`endif

  // Byte-lane views of the operand registers. These feed the lane mux.
  logic [7:0] a_lane_w [NUM_BYTES];
  logic [7:0] b_lane_w [NUM_BYTES];
  logic [7:0] slice_a, slice_b, slice_sum;
  logic       slice_cout;

  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
    assign a_lane_w[gi] = a_q[gi*8 +: 8];
    assign b_lane_w[gi] = b_q[gi*8 +: 8];
    // Only the lane currently in the slice is rewritten. Every other lane holds.
    assign sum_d[gi*8 +: 8] = (state_q == RUN && k_q == K_W'(gi)) ? slice_sum
                                                                    : sum_q[gi*8 +: 8];
  end

  assign slice_a = a_lane_w[k_q];
  assign slice_b = b_lane_w[k_q];

  // 8-bit carry-lookahead slice. Each carry is a flat sum of products of
  // generate/propagate terms, so no carry ripples from bit to bit.
  logic [7:0] gen_w, prop_w;
  logic [8:0] carry_w;
  always_comb begin
    logic acc;
    logic prod;
    acc    = 1'b0;
    prod   = 1'b0;
    gen_w  = slice_a & slice_b;
    prop_w = slice_a ^ slice_b;
    carry_w    = '0;
    carry_w[0] = carry_q;
    for (int i = 0; i < 8; i++) begin
      acc  = gen_w[i];
      prod = prop_w[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prod & gen_w[j]);
        prod = prod & prop_w[j];
      end
      carry_w[i+1] = acc | (prod & carry_q);
    end
    slice_sum  = prop_w ^ carry_w[7:0];
    slice_cout = carry_w[8];
  end

  // FSM next-state logic, lane sequencing, and calculation of the final flags.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_eff;
          carry_d = carry_init;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = slice_cout;
        k_d     = k_q + K_W'(1);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = DONE;
          cout_d  = slice_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[7] != a_q[WIDTH-1]);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla8_seq_adder.sv
// Testbench for cla8_seq_adder. It applies directed and randomized operations
// and compares each result with a reference model based on integer arithmetic.
module tb_cla8_seq_adder;

  localparam int WIDTH     = 32;
  localparam int NUM_BYTES = WIDTH / 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  cla8_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: {cout,sum} = a + b_eff + carry_init. Overflow means the
  // true signed result does not fit in WIDTH bits.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                input logic mcin, input logic msub,
                                output logic [31:0] es, output logic ec, output logic eo);
    logic [31:0] beff;
    logic        cinit;
    logic [32:0] full;
    longint      sf;
`ifdef CLA_SEQ_SUB_EN
    beff  = msub ? ~mb : mb;
    cinit = msub ? 1'b1 : mcin;
`else
    beff  = mb;
    cinit = mcin;
    if (msub) beff = mb;
`endif
    full = {1'b0, ma} + {1'b0, beff} + 33'(cinit);
    sf   = longint'($signed(ma)) + longint'($signed(beff)) + longint'(cinit);
    es   = full[31:0];
    ec   = full[32];
    eo   = (sf != longint'($signed(full[31:0])));
  endfunction

  // Runs one full operation. During DONE the consumer stalls for 'stall'
  // cycles, and each stall cycle issues a request that must be ignored.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_b,
                        input logic tcin, input logic tsub, input int stall);
    logic [31:0] es;
    logic        ec, eo;
    int          n;
    model(ta, tb_b, tcin, tsub, es, ec, eo);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 64'(n < 50), 64'd1);
    a = ta; b = tb_b; cin = tcin; sub = tsub;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'(NUM_BYTES));
    check("sum", 64'(sum), 64'(es));
    check("cout", 64'(cout), 64'(ec));
    check("ovf", 64'(ovf), 64'(eo));
    check("ready_busy", 64'(in_ready), 64'd0);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(negedge clk);
      in_valid = 1'b0;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_sum", 64'(sum), 64'(es));
      check("hold_flags", 64'({cout, ovf}), 64'({ec, eo}));
      check("hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drop_valid", 64'(out_valid), 64'd0);
    check("ready_back", 64'(in_ready), 64'd1);
    $display("op a=%08h b=%08h cin=%0b sub=%0b -> sum=%08h cout=%0b ovf=%0b (exp %08h %0b %0b)",
             ta, tb_b, tcin, tsub, sum, cout, ovf, es, ec, eo);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_flags", 64'({cout, ovf}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(in_ready), 64'd1);

    // Directed cases.
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0);
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 0);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
    run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 0);
    run_op(32'd7, 32'd5, 1'b0, 1'b1, 0);
    run_op(32'd5, 32'd7, 1'b0, 1'b1, 0);
    run_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 1);
    // Backpressure: three stalled cycles with ignored requests.
    run_op(32'h0F0F0F0F, 32'hF0F0F0F1, 1'b0, 1'b0, 3);
    @(negedge clk);
    check("no_capture_valid", 64'(out_valid), 64'd0);
    check("no_capture_ready", 64'(in_ready), 64'd1);

    // Reset after two lanes have completed.
    a = 32'hDEADBEEF; b = 32'h01020304; cin = 1'b1; sub = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_valid", 64'(out_valid), 64'd0);
    check("midrun_sum", 64'(sum), 64'd0);
    check("midrun_ready", 64'(in_ready), 64'd0);
    check("midrun_flags", 64'({cout, ovf}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(in_ready), 64'd1);
    check("post_rst_valid", 64'(out_valid), 64'd0);
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 0);
    check("post_rst_sum", 64'(sum), 64'h23456789);

    // Randomized operations with random stalls.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 0) rb = ~ra;
      run_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
